// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and types for the CIFAR record front end
package cnn_pkg;
  localparam int IMG_DIM = 32;
  localparam int NUM_CHAN = 3;
  localparam int PIX_PER_REC = IMG_DIM * IMG_DIM * NUM_CHAN;
  localparam int LABEL_MAX = 9;
  localparam int LABEL_W = 4;
  typedef enum logic {LABEL, PIXELS} loader_state_t;
  typedef struct packed {
    logic [4:0] row_idx;
    logic [1:0] chan;
    logic       first;
    logic       last;
  } row_tag_t;
endpackage

// File: rtl/loader_row_buf.sv
// loader_row_buf: one row of samples with its tag and a full flag
module loader_row_buf #(
  parameter int WIDTH = 9,
  parameter int IMG_DIM = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [4:0]               wr_idx,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     set,
  input  cnn_pkg::row_tag_t        tag_in,
  input  logic                     clr,
  output logic                     full,
  output logic [IMG_DIM*WIDTH-1:0] row,
  output cnn_pkg::row_tag_t        tag
);
  import cnn_pkg::*;
  // each accepted sample lands in its column slot
  always_ff @(posedge clk or posedge rst)
    if (rst) row <= '0;
    else if (wr_en) row[wr_idx*WIDTH +: WIDTH] <= wr_data;
  // tag latches with the final sample; full sets on fill, clears on drain
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= 1'b0;
      tag  <= '0;
    end else begin
      full <= set ? 1'b1 : clr ? 1'b0 : full;
      if (set) tag <= tag_in;
    end
endmodule

// File: rtl/cifar_row_loader.sv
// cifar_row_loader: CIFAR-10 byte stream to double-buffered 32-pixel rows; PIXEL_CENTER_EN centres samples to -128..127
module cifar_row_loader #(
  parameter int WIDTH = 9,
  parameter int IMG_DIM = 32,
  parameter int NUM_CHAN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [7:0]               s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [IMG_DIM*WIDTH-1:0] m_row,
  output logic [4:0]               m_row_idx,
  output logic [1:0]               m_chan,
  output logic                     m_first,
  output logic                     m_last,
  output logic                     label_valid,
  output logic [3:0]               label,
  output logic                     label_err
);
  import cnn_pkg::*;
  localparam logic [4:0] LAST_IDX = 5'(IMG_DIM - 1);
  localparam logic [1:0] LAST_CH = 2'(NUM_CHAN - 1);
  loader_state_t state, state_nx;
  logic [4:0] col, row;
  logic [1:0] chan;
  logic rdy_q, wr_sel, rd_sel, acc, lbl_acc, pix_we, row_done, rec_done, m_fire;
  logic [1:0] full;
  logic [IMG_DIM*WIDTH-1:0] rows [2];
  row_tag_t tags [2];
  row_tag_t tag_in;
  logic [WIDTH-1:0] pix;
`ifdef PIXEL_CENTER_EN
  logic signed [8:0] ctr;
  assign ctr = $signed({1'b0, s_data}) - 9'sd128;
  assign pix = WIDTH'(ctr);
`else
  assign pix = WIDTH'(s_data);
`endif
  assign s_ready = rdy_q && (state == LABEL || !full[wr_sel]);
  assign acc = s_valid && s_ready;
  assign m_valid = full[rd_sel];
  assign m_fire = m_valid && m_ready;
  assign m_row = rows[rd_sel];
  assign m_row_idx = tags[rd_sel].row_idx;
  assign m_chan = tags[rd_sel].chan;
  assign m_first = tags[rd_sel].first;
  assign m_last = tags[rd_sel].last;
  // decode the accepted byte as label or pixel and find row/record ends
  always_comb begin
    lbl_acc = acc && state == LABEL;
    pix_we = acc && state == PIXELS;
    row_done = pix_we && col == LAST_IDX;
    rec_done = row_done && row == LAST_IDX && chan == LAST_CH;
    state_nx = lbl_acc ? PIXELS : rec_done ? LABEL : state;
    tag_in = '{row_idx: row, chan: chan, first: row == 5'd0 && chan == 2'd0,
               last: row == LAST_IDX && chan == LAST_CH};
  end
  // state register; s_ready stays low until the first edge after reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LABEL;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nx;
      rdy_q <= 1'b1;
    end
  // column/row/channel position and fill/drain buffer pointers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col    <= '0;
      row    <= '0;
      chan   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (pix_we) col <= row_done ? 5'd0 : col + 5'd1;
      if (row_done) begin
        wr_sel <= ~wr_sel;
        row    <= row == LAST_IDX ? 5'd0 : row + 5'd1;
        if (row == LAST_IDX) chan <= chan == LAST_CH ? 2'd0 : chan + 2'd1;
      end
      if (m_fire) rd_sel <= ~rd_sel;
    end
  // label capture with one-cycle valid and range-error pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      label       <= '0;
      label_valid <= 1'b0;
      label_err   <= 1'b0;
    end else begin
      label       <= lbl_acc ? s_data[3:0] : label;
      label_valid <= lbl_acc;
      label_err   <= lbl_acc && s_data > 8'(LABEL_MAX);
    end
  for (genvar i = 0; i < 2; i++) begin : g_buf
    loader_row_buf #(.WIDTH(WIDTH), .IMG_DIM(IMG_DIM)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (pix_we && wr_sel == 1'(i)),
      .wr_idx  (col),
      .wr_data (pix),
      .set     (row_done && wr_sel == 1'(i)),
      .tag_in  (tag_in),
      .clr     (m_fire && rd_sel == 1'(i)),
      .full    (full[i]),
      .row     (rows[i]),
      .tag     (tags[i])
    );
  end
endmodule

// File: tb/tb_cifar_row_loader.sv
// tb_cifar_row_loader: directed checks of label handling, row assembly, backpressure and reset
module tb_cifar_row_loader;
  localparam int WIDTH = 9;
  localparam int IMG_DIM = 32;
  localparam int REC = 3073;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid, s_ready, m_valid, m_ready, m_first, m_last, label_valid, label_err;
  logic [7:0] s_data;
  logic [IMG_DIM*WIDTH-1:0] m_row;
  logic [4:0] m_row_idx;
  logic [1:0] m_chan;
  logic [3:0] label;
  int n_assert = 0, n_fail = 0;
  int idx, k, nl, stream_len, pct, cyc;
  logic [7:0] lab [8];

  cifar_row_loader #(.WIDTH(WIDTH), .IMG_DIM(IMG_DIM), .NUM_CHAN(3)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_row(m_row), .m_row_idx(m_row_idx),
    .m_chan(m_chan), .m_first(m_first), .m_last(m_last), .label_valid(label_valid),
    .label(label), .label_err(label_err));

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_at(input int n);
    int o = n % REC;
    return o == 0 ? lab[n / REC] : 8'((o - 1) % 256);
  endfunction

  function automatic logic [WIDTH-1:0] samp(input logic [7:0] b);
`ifdef PIXEL_CENTER_EN
    return WIDTH'(int'(b) - 128);
`else
    return WIDTH'(b);
`endif
  endfunction

  function automatic logic [IMG_DIM*WIDTH+8:0] exp_row(input int kk);
    int q = kk % 96;
    logic [IMG_DIM*WIDTH-1:0] r;
    for (int j = 0; j < IMG_DIM; j++) r[j*WIDTH +: WIDTH] = samp(8'((q * 32 + j) % 256));
    return {r, 5'(q % 32), 2'(q / 32), q == 0, q == 95};
  endfunction

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {s_ready, m_valid, m_row, m_row_idx, m_chan, m_first, m_last, label_valid, label, label_err}, '0);
  endtask

  task automatic drive();
    s_valid = idx < stream_len;
    s_data = idx < stream_len ? byte_at(idx) : 8'h00;
    m_ready = $urandom_range(99) < pct;
  endtask

  task automatic observe();
    if (label_valid || label_err) begin
      chk("label", {label_valid, label_err, label}, {1'b1, lab[nl] > 8'd9, lab[nl][3:0]});
      if (nl < 7) nl++;
    end
    if (m_valid && m_ready) begin
      chk($sformatf("row%0d", k), {m_row, m_row_idx, m_chan, m_first, m_last}, exp_row(k));
      k++;
    end
    if (s_valid && s_ready) idx++;
  endtask

  task automatic step();
    observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until(input int bg, input int rg, output int c);
    c = 0;
    while ((idx < bg || k < rg) && c < 20000) begin
      step();
      c++;
    end
    if (c >= 20000) begin
      n_assert++;
      n_fail++;
      $error("FAIL timeout observed bytes=%0d rows=%0d expected bytes=%0d rows=%0d", idx, k, bg, rg);
    end
  endtask

  initial begin
    s_valid = 1'b0;
    s_data = 8'h00;
    m_ready = 1'b0;
    pct = 100;
    stream_len = 0;
    idx = 0;
    k = 0;
    nl = 0;
    lab = '{8'h07, 8'h0C, 8'h01, 8'h03, 8'h09, 8'h05, 8'h02, 8'h00};
    #12;
    chk_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("ready_at_release", s_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("ready_after_release", s_ready, 1'b1);
    // record 1: label 7, consumer always ready, full rate
    stream_len = 5 * REC;
    drive();
    run_until(REC, 96, cyc);
    chk("throughput", cyc <= 3076, 1'b1);
    chk("labels_rec1", nl, 1);
    // record 2: out-of-range label 0x0C still yields all rows
    run_until(2 * REC, 192, cyc);
    chk("labels_rec2", nl, 2);
    // record 3: consumer stalled, two rows fill both buffers
    pct = 0;
    m_ready = 1'b0;
    run_until(2 * REC + 65, 192, cyc);
    for (int i = 0; i < 3; i++) step();
    chk("stall_bytes", idx, 2 * REC + 65);
    chk("stall_ready", s_ready, 1'b0);
    chk("stall_valid", m_valid, 1'b1);
    pct = 100;
    m_ready = 1'b1;
    observe();
    @(posedge clk);
    #1;
    chk("ready_after_drain", s_ready, 1'b1);
    drive();
    run_until(3 * REC, 288, cyc);
    chk("labels_rec3", nl, 3);
    // records 4 and 5 back to back with a 50% consumer
    pct = 50;
    run_until(5 * REC, 480, cyc);
    chk("labels_rec5", nl, 5);
    chk("rows_total", k, 480);
    // reset mid-record after 40 pixels
    lab[0] = 8'h05;
    idx = 0;
    k = 0;
    nl = 0;
    stream_len = REC;
    pct = 100;
    drive();
    run_until(41, 0, cyc);
    rst = 1'b1;
    #1;
    chk_zero("mid_reset_outputs");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("ready_at_release2", s_ready, 1'b0);
    lab[0] = 8'h02;
    idx = 0;
    k = 0;
    nl = 0;
    @(posedge clk);
    #1;
    drive();
    run_until(REC, 96, cyc);
    chk("labels_after_reset", nl, 1);
    chk("rows_after_reset", k, 96);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
